iter_shifter: RTL and testbench
===============================

Name: iter_shifter

Overview:
- Parametrised multi-cycle shift unit; successor to the fixed 2-bit left-shift wiring used in the datapath.
- Shifts a WIDTH-bit operand by a variable amount, at most STEP bit positions per clock, with four modes.
- Uses valid/ready handshakes on input and output, and reports the last bit shifted out.
- Sits beside the ALU for shift instructions and for branch/jump offset scaling.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 2).
- SHAMT_W, 5, shift-amount port width; must be >= clog2(WIDTH).
- STEP, 2, maximum bit positions shifted per clock (1 <= STEP <= WIDTH-1).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- abort  input  1  synchronous cancel of any operation in flight.
- in_valid  input  1  operand/command valid.
- in_ready  output  1  unit can accept a command.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount, unsigned.
- in_op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result.
- out_cout  output  1  last bit shifted or rotated out.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; out_data=0, out_valid=0, out_cout=0, remaining count=0.
- After reset, in_ready=1.
- FSM states: IDLE, SHIFT, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE, on accept (in_valid && in_ready at the edge):
  - Latch in_data into the work register, in_shamt into remaining, in_op into the op register; clear cout.
  - Next state is DONE if in_shamt==0, otherwise SHIFT.
- SHIFT, each edge:
  - step = min(remaining, STEP).
  - Shift the work register by step per op:
    - SLL: zero fill at the LSB.
    - SRL: zero fill at the MSB.
    - SRA: fill with the original MSB.
    - ROL: bits leaving the MSB re-enter at the LSB.
  - cout = the last bit to leave the word in that step: the MSB side for SLL/ROL, the LSB side for SRL/SRA.
  - remaining -= step. When the result is 0, go to DONE.
- Latency: out_valid rises 1 + ceil(in_shamt/STEP) edges after the accept edge (1 edge when shamt=0).
  - WIDTH=32, STEP=2, shamt=31 -> 17 edges.
- DONE:
  - out_data and out_cout are held stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready, go to IDLE and deassert out_valid.
  - out_data keeps its last value after the handshake.
  - No same-cycle accept of a new command while in DONE.
- shamt >= WIDTH (possible only when SHAMT_W > clog2(WIDTH)): the iterative semantics define the result.
  - SLL/SRL give 0; SRA gives all sign bits; ROL gives rotate by shamt mod WIDTH.
  - Latency is still ceil(shamt/STEP)+1.
- abort=1 at an edge in any state:
  - Forces IDLE and clears out_valid and remaining. out_data and out_cout are unchanged.
  - abort has priority over accept and over the output handshake in the same cycle.
- in_valid while not IDLE: ignored; the command is not captured.
- in_data, in_shamt and in_op are sampled only at the accept edge; later changes have no effect.
- rst_n low mid-operation: returns to the reset state immediately; the operation is lost.

Test Plan (WIDTH=32, STEP=2):
- SLL, data 0x0000_0001, shamt 2 -> out_data 0x0000_0004, out_cout 0, out_valid 2 edges after accept.
- SLL, data 0xF000_0001, shamt 3 (odd, final step of 1) -> out_data 0x8000_0008, out_cout 1, 3 edges.
- SRA, data 0x8000_0000, shamt 31 -> out_data 0xFFFF_FFFF, out_cout 0, 17 edges; in_ready 0 throughout.
- ROL, data 0xDEAD_BEEF, shamt 4 -> out_data 0xEADB_EEFD, out_cout 1; SRL 0x1234_5678, shamt 0 -> unchanged, out_cout 0, 1 edge.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and pulse in_valid meanwhile.
  - out_data and out_valid stay stable and the command is not captured.
  - Raise out_ready -> IDLE next edge, in_ready=1.
- Abort and reset:
  - abort in the 3rd SHIFT cycle of SRL shamt 20 -> IDLE next edge, out_valid never rises.
  - rst_n low mid-SHIFT -> out_valid, out_data and out_cout 0 immediately.
  - A fresh command after either completes correctly.

Source files
------------

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shift unit with SLL/SRL/SRA/ROL modes, STEP bits per clock,
// valid/ready handshakes on both sides and a carry-out of the last bit shifted out.  Rev 1.0
`default_nettype none

module iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_cout
);

  localparam int STEP_W = $clog2(STEP + 1);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] remaining;
  logic [1:0]         op;
  logic               cout;

  logic [STEP_W-1:0]  step;
  logic [WIDTH-1:0]   shifted;
  logic               cout_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = work;
  assign out_cout  = cout;

  always_comb begin
    step = STEP_W'(STEP);
    if (remaining < SHAMT_W'(STEP))
      step = STEP_W'(remaining);
  end

  // Each candidate step size is a fixed shift; the live step selects one of them.
  always_comb begin
    shifted  = work;
    cout_nxt = cout;
    for (int k = 1; k <= STEP; k++) begin
      if (step == STEP_W'(k)) begin
        case (op)
          OP_SLL: begin
            shifted  = work << k;
            cout_nxt = work[WIDTH-k];
          end
          OP_SRL: begin
            shifted  = work >> k;
            cout_nxt = work[k-1];
          end
          OP_SRA: begin
            shifted  = $signed(work) >>> k;
            cout_nxt = work[k-1];
          end
          OP_ROL: begin
            shifted  = (work << k) | (work >> (WIDTH - k));
            cout_nxt = work[WIDTH-k];
          end
          default: begin
            shifted  = work;
            cout_nxt = cout;
          end
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = (in_shamt == '0) ? DONE : SHIFT;
      SHIFT: if (remaining == SHAMT_W'(step)) state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      remaining <= '0;
      op        <= OP_SLL;
      cout      <= 1'b0;
    end else if (abort) begin
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work      <= in_data;
            remaining <= in_shamt;
            op        <= in_op;
            cout      <= 1'b0;
          end
        end
        SHIFT: begin
          work      <= shifted;
          cout      <= cout_nxt;
          remaining <= remaining - SHAMT_W'(step);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed self-checking bench for iter_shifter (WIDTH=32, STEP=2).
`default_nettype none

module tb_iter_shifter;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int STEP    = 2;

  logic               clk;
  logic               rst_n;
  logic               abort;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_cout;

  int checks   = 0;
  int failures = 0;

  iter_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cout  (out_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one active edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a command, scramble the inputs after the accept edge, and wait for out_valid.
  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] data,
                       input logic [4:0] shamt, input logic [31:0] exp_data,
                       input logic exp_cout, input int exp_lat);
    int edges;
    int ready_seen;
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    in_shamt = shamt;
    tick();
    in_valid   = 1'b0;
    in_data    = ~data;
    in_shamt   = ~shamt;
    in_op      = ~op;
    edges      = 1;
    ready_seen = 0;
    while (!out_valid && edges < 200) begin
      if (in_ready) ready_seen++;
      tick();
      edges++;
    end
    check({tag, "_lat"},  64'(edges), 64'(exp_lat));
    check({tag, "_data"}, 64'(out_data), 64'(exp_data));
    check({tag, "_cout"}, 64'(out_cout), 64'(exp_cout));
    check({tag, "_busy"}, 64'(ready_seen), 64'd0);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_drain_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] held;
    int          seen;

    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_shamt = '0; in_op = 2'b00;
    tick();
    tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_cout",  64'(out_cout),  64'd0);
    check("rst_ready", 64'(in_ready),  64'd1);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 64'(in_ready), 64'd1);

    issue("sll2",  2'b00, 32'h0000_0001, 5'd2,  32'h0000_0004, 1'b0, 2);
    drain("sll2");
    issue("sll3",  2'b00, 32'hF000_0001, 5'd3,  32'h8000_0008, 1'b1, 3);
    drain("sll3");
    issue("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 17);
    drain("sra31");
    issue("rol4",  2'b11, 32'hDEAD_BEEF, 5'd4,  32'hEADB_EEFD, 1'b1, 3);
    drain("rol4");
    issue("srl0",  2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1);
    drain("srl0");
    issue("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 17);
    drain("srl31");

    // Backpressure: result must hold while pulsed commands are ignored.
    issue("bp", 2'b00, 32'h0000_00A5, 5'd4, 32'h0000_0A50, 1'b0, 3);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2) == 0;
      in_data  = 32'h5555_0000 + 32'(i);
      in_shamt = 5'd1;
      in_op    = 2'b01;
      tick();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data",  64'(out_data),  64'(held));
    end
    in_valid = 1'b0;
    drain("bp");
    check("bp_keep_data", 64'(out_data), 64'(held));
    tick();
    tick();
    check("bp_no_capture", 64'(out_valid), 64'd0);

    // Abort in the 3rd SHIFT cycle of SRL by 20; two steps (4 bits) already applied.
    in_valid = 1'b1; in_op = 2'b01; in_data = 32'hABCD_000F; in_shamt = 5'd20;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ready", 64'(in_ready), 64'd1);
    check("abort_data",  64'(out_data), 64'h0ABC_D000);
    check("abort_cout",  64'(out_cout), 64'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("abort_no_valid", 64'(seen), 64'd0);

    // Abort beats accept in the same cycle.
    in_valid = 1'b1; abort = 1'b1; in_op = 2'b00; in_data = 32'h1; in_shamt = 5'd0;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    tick();
    check("abort_vs_accept", 64'(out_valid), 64'd0);

    issue("after_abort", 2'b11, 32'h8000_0001, 5'd1, 32'h0000_0003, 1'b1, 2);
    drain("after_abort");

    // Asynchronous reset mid-SHIFT.
    in_valid = 1'b1; in_op = 2'b00; in_data = 32'hFFFF_FFFF; in_shamt = 5'd20;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data",  64'(out_data),  64'd0);
    check("arst_cout",  64'(out_cout),  64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_ready", 64'(in_ready), 64'd1);

    issue("after_rst", 2'b10, 32'h4000_0000, 5'd5, 32'h0200_0000, 1'b0, 4);
    drain("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
